id_hazard_ctrl: RTL and testbench

- Decode-stage hazard controller for the 5-stage pipeline.
- Keeps a three-slot shadow scoreboard of in-flight writers in EX, MEM and WB, and compares the current ID instruction's sources against it.
- Drives the bubble input of the ID/EX register and the enables of PC and IF/ID.
- Also handles taken-branch flush, halt freeze and a saturating stall-cycle counter.

---
 rtl/id_hazard_ctrl_pkg.sv | 17 +
 rtl/id_hazard_ctrl_hz_slot_cmp.sv | 18 +
 rtl/id_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_id_hazard_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared decode-stage definitions: register index width, the NOP encoding and
// the scoreboard slot record used by the hazard controller.
package id_hazard_ctrl_pkg;

    localparam int REG_W = 3;

    localparam logic [15:0] NOP_INSN = 16'h0800;

    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] rd;
        logic             ld;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{vld: 1'b0, rd: '0, ld: 1'b0};

endpackage

// File: rtl/id_hazard_ctrl_hz_slot_cmp.sv
// Compares one in-flight writer slot against the two ID source registers.
module hz_slot_cmp
    import id_hazard_ctrl_pkg::*;
(
    input  slot_t            slot,
    input  logic [REG_W-1:0] rs_id,
    input  logic             rs_vld,
    input  logic [REG_W-1:0] rt_id,
    input  logic             rt_vld,
    output logic             hit_rs,
    output logic             hit_rt
);

    // R0 is writable, so index 0 gets no exemption
    assign hit_rs = rs_vld & slot.vld & (slot.rd == rs_id);
    assign hit_rt = rt_vld & slot.vld & (slot.rd == rt_id);

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard controller: shadow scoreboard of EX/MEM/WB writers,
// bubble/enable generation, branch flush, halt freeze and stall counter.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter bit FORWARD   = 1'b1,
    parameter bit RF_BYPASS = 1'b1
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_en,
    input  logic [REG_W-1:0] rs_id,
    input  logic             rs_vld,
    input  logic [REG_W-1:0] rt_id,
    input  logic             rt_vld,
    input  logic [REG_W-1:0] rd_id,
    input  logic             regwr_id,
    input  logic             load_id,
    input  logic             halt_id,
    input  logic             flush_ex,
    output logic             bubble,
    output logic             ifid_en,
    output logic             pc_en,
    output logic             halted,
    output logic [15:0]      stall_cnt
);

    slot_t      slot_ex;
    slot_t      slot_mem;
    slot_t      slot_wb;
    logic [2:0] hit_rs;
    logic [2:0] hit_rt;
    logic [2:0] hit;
    logic       hazard;
    slot_t      slot_id;

    hz_slot_cmp u_cmp_ex (
        .slot   (slot_ex),
        .rs_id  (rs_id),
        .rs_vld (rs_vld),
        .rt_id  (rt_id),
        .rt_vld (rt_vld),
        .hit_rs (hit_rs[0]),
        .hit_rt (hit_rt[0])
    );

    hz_slot_cmp u_cmp_mem (
        .slot   (slot_mem),
        .rs_id  (rs_id),
        .rs_vld (rs_vld),
        .rt_id  (rt_id),
        .rt_vld (rt_vld),
        .hit_rs (hit_rs[1]),
        .hit_rt (hit_rt[1])
    );

    hz_slot_cmp u_cmp_wb (
        .slot   (slot_wb),
        .rs_id  (rs_id),
        .rs_vld (rs_vld),
        .rt_id  (rt_id),
        .rt_vld (rt_vld),
        .hit_rs (hit_rs[2]),
        .hit_rt (hit_rt[2])
    );

    assign hit = hit_rs | hit_rt;

    // With the EX/MEM bypass only a load in EX cannot be forwarded in time
    always_comb begin
        hazard = 1'b0;
        if (FORWARD) begin
            hazard = hit[0] & slot_ex.ld;
        end else begin
            hazard = hit[0] | hit[1];
        end
        if (!RF_BYPASS) begin
            hazard = hazard | hit[2];
        end
    end

    assign bubble  = flush_ex | hazard;
    assign ifid_en = pipe_en & ~halted & (flush_ex | ~hazard);
    assign pc_en   = ifid_en;

    always_comb begin
        slot_id = SLOT_EMPTY;
        if (!bubble) begin
            slot_id = '{vld: regwr_id, rd: rd_id, ld: load_id};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_ex   <= SLOT_EMPTY;
            slot_mem  <= SLOT_EMPTY;
            slot_wb   <= SLOT_EMPTY;
            halted    <= 1'b0;
            stall_cnt <= 16'd0;
        end else if (pipe_en) begin
            slot_ex  <= slot_id;
            slot_mem <= slot_ex;
            slot_wb  <= slot_mem;
            // A killed or stalled HALT never reaches EX, so it must not freeze fetch
            if (halt_id && !bubble) begin
                halted <= 1'b1;
            end
            if (hazard && !flush_ex && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: three parameterisations share one
// stimulus stream and are checked every cycle against a per-config model.
module tb_id_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pipe_en;
    logic [2:0] rs_id;
    logic       rs_vld;
    logic [2:0] rt_id;
    logic       rt_vld;
    logic [2:0] rd_id;
    logic       regwr_id;
    logic       load_id;
    logic       halt_id;
    logic       flush_ex;

    logic [2:0]  bub;
    logic [2:0]  ife;
    logic [2:0]  pce;
    logic [2:0]  hlt;
    logic [15:0] cnt [3];

    int n_run  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // cfg0: FORWARD=1 RF_BYPASS=1, cfg1: FORWARD=0 RF_BYPASS=1, cfg2: FORWARD=0 RF_BYPASS=0
    bit [2:0] fwd_cfg = 3'b001;
    bit [2:0] byp_cfg = 3'b011;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.FORWARD(1'b1), .RF_BYPASS(1'b1)) u_f1 (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .rs_id(rs_id), .rs_vld(rs_vld),
        .rt_id(rt_id), .rt_vld(rt_vld), .rd_id(rd_id), .regwr_id(regwr_id),
        .load_id(load_id), .halt_id(halt_id), .flush_ex(flush_ex),
        .bubble(bub[0]), .ifid_en(ife[0]), .pc_en(pce[0]), .halted(hlt[0]),
        .stall_cnt(cnt[0])
    );

    id_hazard_ctrl #(.FORWARD(1'b0), .RF_BYPASS(1'b1)) u_f0b1 (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .rs_id(rs_id), .rs_vld(rs_vld),
        .rt_id(rt_id), .rt_vld(rt_vld), .rd_id(rd_id), .regwr_id(regwr_id),
        .load_id(load_id), .halt_id(halt_id), .flush_ex(flush_ex),
        .bubble(bub[1]), .ifid_en(ife[1]), .pc_en(pce[1]), .halted(hlt[1]),
        .stall_cnt(cnt[1])
    );

    id_hazard_ctrl #(.FORWARD(1'b0), .RF_BYPASS(1'b0)) u_f0b0 (
        .clk(clk), .rst(rst), .pipe_en(pipe_en), .rs_id(rs_id), .rs_vld(rs_vld),
        .rt_id(rt_id), .rt_vld(rt_vld), .rd_id(rd_id), .regwr_id(regwr_id),
        .load_id(load_id), .halt_id(halt_id), .flush_ex(flush_ex),
        .bubble(bub[2]), .ifid_en(ife[2]), .pc_en(pce[2]), .halted(hlt[2]),
        .stall_cnt(cnt[2])
    );

    task automatic check(input string name, input int cfg,
                         input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cfg%0d at %0t: got %0h, expected %0h", name, cfg, $time, act, exp);
        end
    endtask

    // Model: writers in flight, index 0 = one ahead (EX), 1 = two ahead, 2 = three ahead
    bit       m_vld [3][3];
    bit [2:0] m_rd  [3][3];
    bit       m_ld  [3][3];
    bit       m_halt[3];
    int       m_cnt [3];
    bit       n_vld [3][3];
    bit [2:0] n_rd  [3][3];
    bit       n_ld  [3][3];
    bit       n_halt[3];
    int       n_cnt [3];

    function automatic bit model_hz(input int c);
        bit h;
        bit hit;
        bit need;
        h = 1'b0;
        for (int d = 0; d < 3; d++) begin
            hit = m_vld[c][d] && ((rs_vld && m_rd[c][d] == rs_id) ||
                                  (rt_vld && m_rd[c][d] == rt_id));
            case (d)
                0:       need = m_ld[c][d] || !fwd_cfg[c];
                1:       need = !fwd_cfg[c];
                default: need = !byp_cfg[c];
            endcase
            if (hit && need) h = 1'b1;
        end
        return h;
    endfunction

    initial begin
        bit hz;
        bit e_bub;
        bit e_en;
        forever begin
            @(negedge clk);
            n_vld = m_vld; n_rd = m_rd; n_ld = m_ld; n_halt = m_halt; n_cnt = m_cnt;
            for (int c = 0; c < 3; c++) begin
                hz    = model_hz(c);
                e_bub = flush_ex || hz;
                e_en  = pipe_en && !m_halt[c] && (flush_ex || !hz);
                if (chk_en) begin
                    check("bubble",    c, 32'(bub[c]), 32'(e_bub));
                    check("ifid_en",   c, 32'(ife[c]), 32'(e_en));
                    check("pc_en",     c, 32'(pce[c]), 32'(e_en));
                    check("halted",    c, 32'(hlt[c]), 32'(m_halt[c]));
                    check("stall_cnt", c, 32'(cnt[c]), 32'(m_cnt[c]));
                end
                if (!rst) begin
                    for (int d = 0; d < 3; d++) begin
                        n_vld[c][d] = 1'b0; n_rd[c][d] = 3'd0; n_ld[c][d] = 1'b0;
                    end
                    n_halt[c] = 1'b0;
                    n_cnt[c]  = 0;
                end else if (pipe_en) begin
                    for (int d = 2; d > 0; d--) begin
                        n_vld[c][d] = m_vld[c][d-1];
                        n_rd[c][d]  = m_rd[c][d-1];
                        n_ld[c][d]  = m_ld[c][d-1];
                    end
                    n_vld[c][0] = regwr_id && !e_bub;
                    n_rd[c][0]  = rd_id;
                    n_ld[c][0]  = load_id && !e_bub;
                    if (halt_id && !e_bub) n_halt[c] = 1'b1;
                    if (hz && !flush_ex && m_cnt[c] < 65535) n_cnt[c] = m_cnt[c] + 1;
                end
            end
            @(posedge clk);
            m_vld = n_vld; m_rd = n_rd; m_ld = n_ld; m_halt = n_halt; m_cnt = n_cnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] rs, input logic rsv, input logic [2:0] rt,
                         input logic rtv, input logic [2:0] rd, input logic wr,
                         input logic ld);
        rs_id = rs; rs_vld = rsv; rt_id = rt; rt_vld = rtv;
        rd_id = rd; regwr_id = wr; load_id = ld;
        halt_id = 1'b0; flush_ex = 1'b0;
    endtask

    task automatic nop();
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        pipe_en = 1'b1;
        nop();
        tick();
        rst = 1'b1;
        chk_en = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("rst_bubble", c, 32'(bub[c]), 32'd0);
            check("rst_ifid",   c, 32'(ife[c]), 32'd1);
            check("rst_halted", c, 32'(hlt[c]), 32'd0);
            check("rst_cnt",    c, 32'(cnt[c]), 32'd0);
        end

        // Load-use: LD R2 then ADD R3,R2,R1
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        drive(3'd2, 1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b0);
        #1;
        check("lu_bubble", 0, 32'(bub[0]), 32'd1);
        check("lu_ifid",   0, 32'(ife[0]), 32'd0);
        check("lu_pc",     0, 32'(pce[0]), 32'd0);
        tick();
        check("lu_cnt1",   0, 32'(cnt[0]), 32'd1);
        check("lu_adv",    0, 32'(ife[0]), 32'd1);
        repeat (3) tick();
        nop();
        repeat (4) tick();
        check("lu_cnt_f1",   0, 32'(cnt[0]), 32'd1);
        check("lu_cnt_f0b1", 1, 32'(cnt[1]), 32'd2);
        check("lu_cnt_f0b0", 2, 32'(cnt[2]), 32'd3);

        // RAW on ALU result: ADD R1 then SUB R4,R1,R5
        do_reset();
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        tick();
        drive(3'd1, 1'b1, 3'd5, 1'b1, 3'd4, 1'b1, 1'b0);
        #1;
        check("raw_f1_nostall", 0, 32'(bub[0]), 32'd0);
        check("raw_f0_stall",   1, 32'(bub[1]), 32'd1);
        repeat (4) tick();
        nop();
        repeat (4) tick();
        check("raw_cnt_f1",   0, 32'(cnt[0]), 32'd0);
        check("raw_cnt_f0b1", 1, 32'(cnt[1]), 32'd2);
        check("raw_cnt_f0b0", 2, 32'(cnt[2]), 32'd3);

        // Flush in the same cycle as a load-use hazard
        do_reset();
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        drive(3'd2, 1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b0);
        flush_ex = 1'b1;
        #1;
        check("fl_bubble", 0, 32'(bub[0]), 32'd1);
        check("fl_ifid",   0, 32'(ife[0]), 32'd1);
        check("fl_pc",     0, 32'(pce[0]), 32'd1);
        tick();
        drive(3'd3, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        #1;
        check("fl_cnt_f1",   0, 32'(cnt[0]), 32'd0);
        check("fl_cnt_f0",   1, 32'(cnt[1]), 32'd0);
        check("fl_ex_clear", 1, 32'(bub[1]), 32'd0);
        nop();
        repeat (4) tick();

        // HALT
        do_reset();
        nop();
        halt_id = 1'b1;
        #1;
        check("ht_pc_pre", 0, 32'(pce[0]), 32'd1);
        tick();
        nop();
        #1;
        for (int c = 0; c < 3; c++) begin
            check("ht_halted", c, 32'(hlt[c]), 32'd1);
            check("ht_pc",     c, 32'(pce[c]), 32'd0);
            check("ht_ifid",   c, 32'(ife[c]), 32'd0);
        end
        repeat (2) tick();
        check("ht_sticky", 2, 32'(hlt[2]), 32'd1);
        do_reset();
        #1;
        check("ht_rst_halted", 0, 32'(hlt[0]), 32'd0);
        check("ht_rst_pc",     0, 32'(pce[0]), 32'd1);
        halt_id = 1'b1;
        flush_ex = 1'b1;
        tick();
        nop();
        #1;
        check("ht_killed",    0, 32'(hlt[0]), 32'd0);
        check("ht_killed_pc", 0, 32'(pce[0]), 32'd1);

        // pipe_en low while a load-use stall is pending
        do_reset();
        drive(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        tick();
        drive(3'd2, 1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b0);
        pipe_en = 1'b0;
        #1;
        check("pe_bubble", 0, 32'(bub[0]), 32'd1);
        check("pe_ifid",   0, 32'(ife[0]), 32'd0);
        repeat (4) tick();
        check("pe_cnt_hold", 0, 32'(cnt[0]), 32'd0);
        check("pe_still",    0, 32'(bub[0]), 32'd1);
        pipe_en = 1'b1;
        #1;
        check("pe_resume_stall", 0, 32'(ife[0]), 32'd0);
        tick();
        check("pe_resolved", 0, 32'(ife[0]), 32'd1);
        check("pe_cnt",      0, 32'(cnt[0]), 32'd1);
        nop();
        repeat (4) tick();

        // Saturation: self-dependent instruction held in ID
        do_reset();
        drive(3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        repeat (87500) tick();
        check("sat_cnt", 2, 32'(cnt[2]), 32'h0000FFFF);
        repeat (8) tick();
        check("sat_hold", 2, 32'(cnt[2]), 32'h0000FFFF);
        nop();
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
